alu_issue_seq: RTL

- Sequential front end for the 32-bit MIPS-style ALU (aluc-coded; r/zero/carry/negative/overflow outputs).
- Accepts one R-type or I-type instruction word plus register operand values over a valid/ready handshake.
- Decodes the instruction to an aluc code and drives registered a/b/aluc onto the ALU, then captures r and the flags.
- Returns the captured result over a second valid/ready handshake. Sits between the register-read stage and writeback in the multi-cycle CPU.

---
 rtl/alu_issue_if.sv | 45 ++++
 rtl/alu_issue_seq.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/alu_issue_if.sv
// alu_issue_if
//   Bundles the signals between the issue sequencer and its surroundings:
//     instruction side : instr_valid/instr_ready handshake, instr, rs_val, rt_val
//     ALU side         : alu_a, alu_b, alu_aluc out; alu_r and the four flags back
//     result side      : res_valid/res_ready handshake, res_data, res_flags, res_illegal
//   slave  : the sequencer (alu_issue_seq)
//   master : the environment (register-read stage, ALU, writeback consumer)
interface alu_issue_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] rs_val;
  logic [31:0] rt_val;

  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_aluc;
  logic [31:0] alu_r;
  logic        alu_zero;
  logic        alu_carry;
  logic        alu_negative;
  logic        alu_overflow;

  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [3:0]  res_flags;
  logic        res_illegal;

  modport master (
    output instr_valid, instr, rs_val, rt_val,
    output alu_r, alu_zero, alu_carry, alu_negative, alu_overflow,
    output res_ready,
    input  instr_ready, alu_a, alu_b, alu_aluc,
    input  res_valid, res_data, res_flags, res_illegal
  );

  modport slave (
    input  instr_valid, instr, rs_val, rt_val,
    input  alu_r, alu_zero, alu_carry, alu_negative, alu_overflow,
    input  res_ready,
    output instr_ready, alu_a, alu_b, alu_aluc,
    output res_valid, res_data, res_flags, res_illegal
  );
endinterface

// File: rtl/alu_issue_seq.sv
// alu_issue_seq
//   Multi-cycle front end for the 32-bit aluc-coded ALU. Accepts one MIPS
//   R/I-type instruction with its register operands, decodes it to an aluc
//   code, drives registered operands to the ALU for one cycle, captures the
//   result and masked flags, and hands them to the consumer.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : alu_issue_if.slave (instruction, ALU and result signals)
module alu_issue_seq (
  input logic        clk,
  input logic        rst_n,
  alu_issue_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        instr_ready_q;
  logic [31:0] alu_a_q, alu_b_q;
  logic [3:0]  alu_aluc_q;
  logic        carry_en_q, ovf_en_q;
  logic [31:0] res_data_q;
  logic [3:0]  res_flags_q;
  logic        res_illegal_q;

  logic        accept, capture;

  logic [5:0]  opcode, funct;
  logic [15:0] imm;
  logic [31:0] imm_sext, imm_zext;
  logic        dec_legal;
  logic [3:0]  dec_aluc;
  logic [31:0] dec_a, dec_b;
  logic        dec_carry_en, dec_ovf_en;

  // Flags packed as {zero, carry, negative, overflow}; carry/overflow are
  // only meaningful for some ops, so they are gated by the decoded enables.
  function automatic logic [3:0] mask_flags(input logic zero, input logic carry,
                                            input logic neg, input logic ovf,
                                            input logic carry_en, input logic ovf_en);
    return {zero, carry & carry_en, neg, ovf & ovf_en};
  endfunction

  assign opcode   = bus.instr[31:26];
  assign funct    = bus.instr[5:0];
  assign imm      = bus.instr[15:0];
  assign imm_sext = {{16{imm[15]}}, imm};
  assign imm_zext = {16'b0, imm};

  // Instruction decode
  always_comb begin
    dec_legal    = 1'b1;
    dec_aluc     = 4'b0000;
    dec_a        = bus.rs_val;
    dec_b        = bus.rt_val;
    dec_carry_en = 1'b0;
    dec_ovf_en   = 1'b0;
    if (opcode == 6'h00) begin
      case (funct)
        6'h21: begin dec_aluc = 4'b0000; dec_carry_en = 1'b1; end
        6'h20: begin dec_aluc = 4'b0010; dec_ovf_en   = 1'b1; end
        6'h23: begin dec_aluc = 4'b0001; dec_carry_en = 1'b1; end
        6'h22: begin dec_aluc = 4'b0011; dec_ovf_en   = 1'b1; end
        6'h24: dec_aluc = 4'b0100;
        6'h25: dec_aluc = 4'b0101;
        6'h26: dec_aluc = 4'b0110;
        6'h27: dec_aluc = 4'b0111;
        6'h2A: dec_aluc = 4'b1011;
        6'h2B: begin dec_aluc = 4'b1010; dec_carry_en = 1'b1; end
        // Immediate shifts take the amount from the shamt field.
        6'h00: begin dec_aluc = 4'b1110; dec_a = {27'b0, bus.instr[10:6]}; dec_carry_en = 1'b1; end
        6'h02: begin dec_aluc = 4'b1101; dec_a = {27'b0, bus.instr[10:6]}; dec_carry_en = 1'b1; end
        6'h03: begin dec_aluc = 4'b1100; dec_a = {27'b0, bus.instr[10:6]}; dec_carry_en = 1'b1; end
        // Variable shifts use only the low five bits of rs.
        6'h04: begin dec_aluc = 4'b1110; dec_a = {27'b0, bus.rs_val[4:0]}; dec_carry_en = 1'b1; end
        6'h06: begin dec_aluc = 4'b1101; dec_a = {27'b0, bus.rs_val[4:0]}; dec_carry_en = 1'b1; end
        6'h07: begin dec_aluc = 4'b1100; dec_a = {27'b0, bus.rs_val[4:0]}; dec_carry_en = 1'b1; end
        default: dec_legal = 1'b0;
      endcase
    end else begin
      case (opcode)
        6'h08: begin dec_aluc = 4'b0010; dec_b = imm_sext; dec_ovf_en   = 1'b1; end
        6'h09: begin dec_aluc = 4'b0000; dec_b = imm_sext; dec_carry_en = 1'b1; end
        6'h0A: begin dec_aluc = 4'b1011; dec_b = imm_sext; end
        6'h0B: begin dec_aluc = 4'b1010; dec_b = imm_sext; dec_carry_en = 1'b1; end
        6'h0C: begin dec_aluc = 4'b0100; dec_b = imm_zext; end
        6'h0D: begin dec_aluc = 4'b0101; dec_b = imm_zext; end
        6'h0E: begin dec_aluc = 4'b0110; dec_b = imm_zext; end
        6'h0F: begin dec_aluc = 4'b1000; dec_b = imm_zext; dec_a = 32'b0; end
        default: dec_legal = 1'b0;
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        // instr_ready_q also gates the first cycle out of reset.
        if (bus.instr_valid && instr_ready_q) begin
          accept  = 1'b1;
          state_d = dec_legal ? EXEC : RESP;
        end
      end
      EXEC: begin
        capture = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      instr_ready_q <= 1'b0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_aluc_q    <= '0;
      carry_en_q    <= 1'b0;
      ovf_en_q      <= 1'b0;
      res_data_q    <= '0;
      res_flags_q   <= '0;
      res_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_ready_q <= (state_d == IDLE);
      if (accept && dec_legal) begin
        alu_a_q       <= dec_a;
        alu_b_q       <= dec_b;
        alu_aluc_q    <= dec_aluc;
        carry_en_q    <= dec_carry_en;
        ovf_en_q      <= dec_ovf_en;
        res_illegal_q <= 1'b0;
      end
      // Illegal words leave the ALU operands untouched.
      if (accept && !dec_legal) begin
        res_illegal_q <= 1'b1;
        res_data_q    <= '0;
        res_flags_q   <= '0;
      end
      if (capture) begin
        res_data_q  <= bus.alu_r;
        res_flags_q <= mask_flags(bus.alu_zero, bus.alu_carry, bus.alu_negative,
                                  bus.alu_overflow, carry_en_q, ovf_en_q);
      end
    end
  end

  assign bus.instr_ready = instr_ready_q;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_aluc    = alu_aluc_q;
  assign bus.res_valid   = (state_q == RESP);
  assign bus.res_data    = res_data_q;
  assign bus.res_flags   = res_flags_q;
  assign bus.res_illegal = res_illegal_q;

endmodule
